// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache - direct-mapped, one-word-per-line instruction cache between IF and
// the memory controller.
//
// IF presents a PC every cycle. The cache answers with the instruction one
// cycle later. On a miss it sends one word read to the memory controller,
// fills the line, and forwards the returned word if IF is still asking for
// that PC. All outputs are registered, so IF's next-PC logic, which depends
// on IF_flag_out, forms no combinational loop through the cache.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   rdy          in   0 freezes all state and outputs
//   jump_wrong   in   misprediction flush from the ROB
//   IF_PC_in     in   [31:0] fetch address (bits [1:0] ignored)
//   IF_flag_out  out  IF_inst_out is valid this cycle
//   IF_inst_out  out  [31:0] instruction for the PC sampled at the last edge
//   Mem_flag_out out  read request, held high until served
//   Mem_addr_out out  [31:0] word address of the request
//   Mem_flag_in  in   one-cycle done pulse from the memory controller
//   Mem_inst_in  in   [31:0] returned word, valid with Mem_flag_in
// -----------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [31:0] IF_PC_in,
  output logic        IF_flag_out,
  output logic [31:0] IF_inst_out,
  output logic        Mem_flag_out,
  output logic [31:0] Mem_addr_out,
  input  logic        Mem_flag_in,
  input  logic [31:0] Mem_inst_in
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Line storage
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Control state
  logic [0:0]  r_state;
  logic [29:0] r_miss_word;     // miss_PC[31:2]
  logic        r_if_flag;
  logic [31:0] r_if_inst;
  logic        r_mem_flag;
  logic [31:0] r_mem_addr;

  // Address decode of the incoming PC and of the outstanding miss
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_miss_idx;
  logic [TAG_BITS-1:0]   w_miss_tag;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_forward;
  logic                  w_unused_pc_lo;

  assign w_idx      = IF_PC_in[INDEX_BITS+1:2];
  assign w_tag      = IF_PC_in[31:INDEX_BITS+2];
  assign w_miss_idx = r_miss_word[INDEX_BITS-1:0];
  assign w_miss_tag = r_miss_word[29:INDEX_BITS];

  // Byte offset within the word plays no part in lookup.
  assign w_unused_pc_lo = &{1'b0, IF_PC_in[1:0]};

  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Fill happens on the enabled edge where WAIT sees the done pulse.
  assign w_fill = rdy && !rst && (r_state == S_WAIT) && Mem_flag_in;

  // Forward the returned word only if IF still wants this exact word and the
  // fetch stream has not just been flushed.
  assign w_forward = (IF_PC_in[31:2] == r_miss_word) && !jump_wrong;

  // NOTE: tag and data arrays carry no reset; a line is only trusted once its
  // valid bit is set, so clearing the valid vector alone is sufficient and
  // keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= Mem_inst_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every read in
  // this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_miss_word <= '0;
      r_if_flag   <= 1'b0;
      r_if_inst   <= '0;
      r_mem_flag  <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (jump_wrong) begin
            // Flush wins over a simultaneous hit; no lookup is started.
            r_if_flag <= 1'b0;
          end else if (w_hit) begin
            r_if_flag <= 1'b1;
            r_if_inst <= r_data[w_idx];
          end else begin
            r_if_flag   <= 1'b0;
            r_miss_word <= IF_PC_in[31:2];
            r_mem_flag  <= 1'b1;
            r_mem_addr  <= {IF_PC_in[31:2], 2'b00};
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (Mem_flag_in) begin
            // The fill completes even after a flush: the word is
            // architecturally correct whatever path fetched it.
            r_valid[w_miss_idx] <= 1'b1;
            r_mem_flag          <= 1'b0;
            r_state             <= S_IDLE;
            if (w_forward) begin
              r_if_flag <= 1'b1;
              r_if_inst <= Mem_inst_in;
            end else begin
              r_if_flag <= 1'b0;
            end
          end else begin
            // Request cannot be aborted; jump_wrong is ignored here.
            r_if_flag <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IF_flag_out  = r_if_flag;
  assign IF_inst_out  = r_if_inst;
  assign Mem_flag_out = r_mem_flag;
  assign Mem_addr_out = r_mem_addr;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache - directed self-checking bench for icache (INDEX_BITS = 8).
// Inputs change 1 ns after a rising edge; registered outputs are sampled at
// the same point, well clear of the next active edge.
// -----------------------------------------------------------------------------
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jump_wrong;
  logic [31:0] IF_PC_in;
  logic        IF_flag_out;
  logic [31:0] IF_inst_out;
  logic        Mem_flag_out;
  logic [31:0] Mem_addr_out;
  logic        Mem_flag_in;
  logic [31:0] Mem_inst_in;

  int checks   = 0;
  int failures = 0;

  icache #(.INDEX_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .jump_wrong   (jump_wrong),
    .IF_PC_in     (IF_PC_in),
    .IF_flag_out  (IF_flag_out),
    .IF_inst_out  (IF_inst_out),
    .Mem_flag_out (Mem_flag_out),
    .Mem_addr_out (Mem_addr_out),
    .Mem_flag_in  (Mem_flag_in),
    .Mem_inst_in  (Mem_inst_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present pc, expect a miss, answer after a short latency with data and
  // expect it forwarded on the cycle after the done edge.
  task automatic fill(input string tag, input logic [31:0] pc,
                      input logic [31:0] data);
    IF_PC_in = pc;
    step();
    check({tag, "_req"},   {31'd0, Mem_flag_out}, 32'd1);
    check({tag, "_addr"},  Mem_addr_out, {pc[31:2], 2'b00});
    check({tag, "_nofl"},  {31'd0, IF_flag_out}, 32'd0);
    repeat (2) begin
      step();
      check({tag, "_hold"}, {31'd0, Mem_flag_out}, 32'd1);
    end
    Mem_flag_in = 1'b1;
    Mem_inst_in = data;
    step();
    Mem_flag_in = 1'b0;
    Mem_inst_in = 32'hDEAD_BEEF;
    check({tag, "_fwdfl"}, {31'd0, IF_flag_out}, 32'd1);
    check({tag, "_fwdin"}, IF_inst_out, data);
    check({tag, "_drop"},  {31'd0, Mem_flag_out}, 32'd0);
  endtask

  // Present pc for one edge and expect a hit returning data.
  task automatic hit(input string tag, input logic [31:0] pc,
                     input logic [31:0] data);
    IF_PC_in = pc;
    step();
    check({tag, "_fl"},  {31'd0, IF_flag_out}, 32'd1);
    check({tag, "_in"},  IF_inst_out, data);
    check({tag, "_req"}, {31'd0, Mem_flag_out}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    rdy         = 1'b1;
    jump_wrong  = 1'b0;
    IF_PC_in    = 32'h0;
    Mem_flag_in = 1'b0;
    Mem_inst_in = 32'h0;

    // Reset state
    repeat (2) step();
    check("rst_if_flag",  {31'd0, IF_flag_out}, 32'd0);
    check("rst_if_inst",  IF_inst_out, 32'd0);
    check("rst_mem_flag", {31'd0, Mem_flag_out}, 32'd0);
    check("rst_mem_addr", Mem_addr_out, 32'd0);
    rst = 1'b0;

    // Cold miss on 0x0, then preload 0x4 and 0x8
    fill("cold0", 32'h0000_0000, 32'h0000_0013);
    fill("cold4", 32'h0000_0004, 32'h1111_1111);
    fill("cold8", 32'h0000_0008, 32'h2222_2222);

    // Hit streaming at one instruction per cycle
    hit("str0", 32'h0000_0000, 32'h0000_0013);
    hit("str4", 32'h0000_0004, 32'h1111_1111);
    hit("str8", 32'h0000_0008, 32'h2222_2222);
    // Byte offset bits are ignored
    hit("off7", 32'h0000_0007, 32'h1111_1111);

    // Conflict eviction: 0x400 shares index 0 with 0x0
    fill("conf400", 32'h0000_0400, 32'h4444_0400);
    fill("conf000", 32'h0000_0000, 32'h0000_0013);
    fill("conf400b", 32'h0000_0400, 32'h4444_0400);
    fill("conf000b", 32'h0000_0000, 32'h0000_0013);

    // Flush during miss: PC moves away, fill still lands
    IF_PC_in = 32'h0000_0100;
    step();
    check("fl_req",  {31'd0, Mem_flag_out}, 32'd1);
    check("fl_addr", Mem_addr_out, 32'h0000_0100);
    IF_PC_in   = 32'h0000_0200;
    jump_wrong = 1'b1;
    step();
    check("fl_hold", {31'd0, Mem_flag_out}, 32'd1);
    check("fl_wfl",  {31'd0, IF_flag_out}, 32'd0);
    jump_wrong  = 1'b0;
    Mem_flag_in = 1'b1;
    Mem_inst_in = 32'h5555_0100;
    step();
    Mem_flag_in = 1'b0;
    check("fl_nofwd", {31'd0, IF_flag_out}, 32'd0);
    check("fl_drop",  {31'd0, Mem_flag_out}, 32'd0);
    fill("fl200", 32'h0000_0200, 32'h6666_0200);
    hit("fl100", 32'h0000_0100, 32'h5555_0100);

    // Same PC at done edge but flushed: no forward, line still valid
    IF_PC_in = 32'h0000_0301;
    step();
    check("jw_addr", Mem_addr_out, 32'h0000_0300);
    jump_wrong  = 1'b1;
    Mem_flag_in = 1'b1;
    Mem_inst_in = 32'h7777_0300;
    step();
    Mem_flag_in = 1'b0;
    jump_wrong  = 1'b0;
    check("jw_nofwd", {31'd0, IF_flag_out}, 32'd0);
    hit("jw_hit", 32'h0000_0300, 32'h7777_0300);

    // Flush on hit: flag drops, then recovers
    IF_PC_in   = 32'h0000_0004;
    jump_wrong = 1'b1;
    step();
    check("fh_fl", {31'd0, IF_flag_out}, 32'd0);
    jump_wrong = 1'b0;
    hit("fh_rec", 32'h0000_0004, 32'h1111_1111);

    // rdy low during a hit stream: outputs frozen
    hit("rh0", 32'h0000_0000, 32'h0000_0013);
    rdy      = 1'b0;
    IF_PC_in = 32'h0000_0008;
    repeat (3) begin
      step();
      check("rh_fl", {31'd0, IF_flag_out}, 32'd1);
      check("rh_in", IF_inst_out, 32'h0000_0013);
    end
    rdy = 1'b1;
    hit("rh8", 32'h0000_0008, 32'h2222_2222);

    // rdy low during WAIT: request frozen, held done pulse ignored until rdy
    IF_PC_in = 32'h0000_0500;
    step();
    check("rw_req", {31'd0, Mem_flag_out}, 32'd1);
    rdy         = 1'b0;
    Mem_flag_in = 1'b1;
    Mem_inst_in = 32'h8888_0500;
    repeat (3) begin
      step();
      check("rw_hold", {31'd0, Mem_flag_out}, 32'd1);
      check("rw_addr", Mem_addr_out, 32'h0000_0500);
      check("rw_fl",   {31'd0, IF_flag_out}, 32'd0);
    end
    rdy = 1'b1;
    step();
    Mem_flag_in = 1'b0;
    check("rw_fwdfl", {31'd0, IF_flag_out}, 32'd1);
    check("rw_fwdin", IF_inst_out, 32'h8888_0500);
    check("rw_drop",  {31'd0, Mem_flag_out}, 32'd0);

    // Reset mid-WAIT drops the request and invalidates every line
    IF_PC_in = 32'h0000_0600;
    step();
    check("rm_req", {31'd0, Mem_flag_out}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rm_drop", {31'd0, Mem_flag_out}, 32'd0);
    check("rm_addr", Mem_addr_out, 32'd0);
    fill("rm_cold", 32'h0000_0000, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache sitting between IF and the memory controller. It is the responder to IF's fetch interface: IF presents a PC, and the cache returns the 32-bit instruction one cycle later with a valid flag. On a miss it issues a word read to the memory controller, fills the line, and forwards the returned word to IF if that PC is still being requested. Outputs are registered so that IF's combinational next-PC logic (which depends on `IF_flag_out`) forms no loop.

## Interface
Parameters:
- `INDEX_BITS`, 8: line count is 2^INDEX_BITS; index = `IF_PC_in[INDEX_BITS+1:2]`, tag = `IF_PC_in[31:INDEX_BITS+2]`, bits [1:0] ignored.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: low freezes all state and outputs.
- `jump_wrong` in 1: ROB misprediction flush.
- `IF_PC_in` in 32: fetch address from IF.
- `IF_flag_out` out 1: `IF_inst_out` valid this cycle.
- `IF_inst_out` out 32: instruction for the PC sampled at the previous edge.
- `Mem_flag_out` out 1: read request to memory controller, held high until served.
- `Mem_addr_out` out 32: word address of request, `{miss_PC[31:2],2'b00}`.
- `Mem_flag_in` in 1: one-cycle done pulse from memory controller.
- `Mem_inst_in` in 32: returned word, valid with `Mem_flag_in`.

## Operation
- Storage: valid[2^INDEX_BITS], tag array, data array. Reset clears all valid bits; tag/data not reset.
- States: IDLE, WAIT.
- IDLE, each enabled edge (`rdy`=1):
  - `jump_wrong`=1: `IF_flag_out`<=0, no lookup, stay IDLE.
  - hit (valid && tag match on `IF_PC_in`): `IF_flag_out`<=1, `IF_inst_out`<=data.
  - miss: `IF_flag_out`<=0, latch `miss_PC`<=`IF_PC_in`, `Mem_flag_out`<=1, `Mem_addr_out`<=word address, go WAIT.
- WAIT, each enabled edge:
  - `Mem_flag_in`=0: `IF_flag_out`<=0, hold request, stay WAIT (`jump_wrong` ignored; request cannot be aborted).
  - `Mem_flag_in`=1: write line at `miss_PC` index (valid<=1, tag, data<=`Mem_inst_in`); `Mem_flag_out`<=0; go IDLE. Forward: if `IF_PC_in[31:2]`==`miss_PC[31:2]` and `jump_wrong`=0, `IF_flag_out`<=1, `IF_inst_out`<=`Mem_inst_in`; else `IF_flag_out`<=0.
- Fill always completes even after a flush; the line is architecturally correct regardless of speculation.
- Repeated PC (IF stalled by decoder) re-hits and re-presents the same word each cycle; this is required, IF ignores it while stalled.
- No write path; self-modifying code unsupported.

## Timing
- Reset values: `IF_flag_out`=0, `IF_inst_out`=0, `Mem_flag_out`=0, `Mem_addr_out`=0, state IDLE, all valid=0. Reset mid-WAIT returns to IDLE with request dropped.
- Hit latency 1 cycle: PC sampled at edge N, flag/inst valid during cycle N..N+1. Back-to-back hits sustain 1 instruction/cycle.
- Miss: request visible the cycle after the miss edge; forwarded data visible the cycle after the `Mem_flag_in` edge. Total = memory latency + 2 cycles.
- Handshake: memory controller starts a transaction when `Mem_flag_out`=1 while it is idle, pulses `Mem_flag_in` exactly once. Cache drops `Mem_flag_out` at the edge where it samples `Mem_flag_in`=1; the controller must not start a new transaction in the done cycle itself. At most one outstanding request.
- `jump_wrong` and hit on the same edge: flush wins, flag 0.
- `rdy`=0 on the `Mem_flag_in` edge: the pulse is lost; the memory controller shares `rdy` and must hold the pulse while `rdy`=0.

## Test plan
- Cold miss: reset, `IF_PC_in`=0x0, memory returns 0x00000013 after 4 cycles -> `Mem_flag_out` high with addr 0x0 until done; `IF_flag_out`=1, inst 0x00000013 one cycle after done.
- Hit streaming: preload 0x0,0x4,0x8 by misses, then step PC 0x0->0x4->0x8 each cycle -> `IF_flag_out`=1 three consecutive cycles, no memory requests.
- Conflict eviction: fetch 0x0 then 0x400 (same index, INDEX_BITS=8) then 0x0 -> three misses, each fill replaces the line.
- Flush during miss: miss on 0x100, assert `jump_wrong` with PC moved to 0x200 before done -> no forward (`IF_flag_out`=0), line 0x100 valid (later fetch of 0x100 hits), then miss on 0x200.
- Flush on hit: hit at 0x4 with `jump_wrong`=1 same edge -> `IF_flag_out`=0 next cycle.
- `rdy` low for 3 cycles during hit stream and during WAIT -> outputs and request frozen, resume with identical values.
